ipr_write_initiator: RTL
========================

Name: ipr_write_initiator

Overview:
- Bus-master engine that drives the LSU-side IPR write interface.
- It takes a bulk command, pulls DSIZE words from a local valid/ready source stream, and writes each word to the IPR FIFO data register using req/gnt/rvalid handshakes.
- It sits on the producer core's side and feeds the IPR controller's write port; the parent connects its flat ipr_* ports to the IPR_WRITE_IF master modport.
- A grant watchdog aborts the transfer when the FIFO stays full too long.

Parameters:
- DSIZE, 32: data width of the source stream and ipr_wdata_o.
- AWIDTH, 32: IPR address width.
- CNT_W, 16: width of the length and word counters.
- TIMEOUT_LIMIT, 100: maximum consecutive REQ cycles without gnt before error; 0 disables the watchdog.
- BULK_NUMBER, 10: transfer length used when cmd_len_i == 0.

Ports:
- w_clk  in  1  clock.
- w_rst_n  in  1  synchronous active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  high only in IDLE.
- cmd_len_i  in  CNT_W  words to transfer; 0 selects BULK_NUMBER.
- cmd_addr_i  in  AWIDTH  IPR data-register address, latched at accept.
- abort_i  in  1  abort request.
- src_valid_i  in  1  source word valid.
- src_ready_o  out  1  source word accept.
- src_data_i  in  DSIZE  source word.
- ipr_req_o  out  1  IPR request.
- ipr_we_o  out  1  IPR write enable.
- ipr_addr_o  out  AWIDTH  IPR address.
- ipr_wdata_o  out  DSIZE  IPR write data.
- ipr_gnt_i  in  1  IPR grant.
- ipr_rvalid_i  in  1  IPR response valid.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle end-of-transfer pulse.
- error_flag  out  1  sticky timeout flag.
- words_sent_o  out  CNT_W  words completed in the current transfer.

Behaviour:
- Clocking and reset:
  - Single clock w_clk; reset is synchronous and active-low (w_rst_n sampled on the w_clk rising edge).
  - On reset: state = IDLE, cmd_ready_o = 1, and every other output = 0 (including ipr_addr_o, ipr_wdata_o, words_sent_o).
  - Reset mid-transfer drops ipr_req_o on the next edge, with no completion pulse.
- Command accept:
  - Occurs on cmd_valid_i && cmd_ready_o.
  - Latches len = (cmd_len_i == 0) ? BULK_NUMBER : cmd_len_i, and latches addr.
  - Clears words_sent_o and error_flag.
  - Next state: FETCH.
- States:
  - IDLE: waits for a command.
  - FETCH: src_ready_o = 1. On src_valid_i, the word is captured into the wdata register and the state moves to REQ. src_ready_o is 0 in every other state.
  - REQ: ipr_req_o = 1, ipr_we_o = 1. ipr_addr_o and ipr_wdata_o are held stable until gnt. On ipr_gnt_i the state moves to RESP and ipr_req_o drops on the next cycle. req is never withdrawn without gnt, except on abort or timeout.
  - RESP: ipr_req_o = 0. Waits for ipr_rvalid_i, then increments words_sent_o. If words_sent_o + 1 == len, next state is DONE; otherwise FETCH. There is at most one outstanding request.
  - DONE: done_o = 1 for one cycle, then IDLE.
  - ERR: done_o = 1 for one cycle, error_flag set, then IDLE.
- Watchdog:
  - A counter increments each REQ cycle without gnt and clears on gnt or on leaving REQ.
  - When the counter reaches TIMEOUT_LIMIT (TIMEOUT_LIMIT != 0), the state moves to ERR and req drops.
  - gnt arriving in the same cycle as the limit wins; the transfer proceeds.
- Abort (abort_i):
  - In FETCH or REQ without same-cycle gnt: go to DONE; words_sent_o holds its count.
  - In REQ with same-cycle gnt, or in RESP: the abort is registered and honoured after rvalid, going to DONE.
  - Ignored in IDLE.
- Arithmetic and wrap:
  - Counters are unsigned CNT_W.
  - len == 2^CNT_W − 1 is legal; no counter wraps within a transfer.
- Other rules:
  - ipr_rvalid_i arriving outside RESP is ignored.
  - Back-to-back commands: cmd_ready_o rises the cycle after DONE or ERR.
- Throughput: 1 word per 3 cycles minimum (FETCH, REQ, RESP) when src_valid_i and gnt are immediate.

Decomposition:
- Shared package ipr_pkg holds:
  - the state enum ipr_init_state_e (IDLE, FETCH, REQ, RESP, DONE, ERR);
  - the IPR register offsets (DATA = 0x0, FULL = 0x4, EMPTY = 0x8).
- Natural sub-module: ipr_watchdog, a counter with clear/enable/limit inputs and an expire output, reusable on the read side.
- The FSM and datapath stay in ipr_write_initiator.

Test Plan:
- Basic 4-word transfer:
  - Stimulus: reset; cmd_len = 4, addr = 0x1A10_0000; source supplies 0x11, 0x22, 0x33, 0x44; gnt immediate; rvalid one cycle later.
  - Required: four REQ pulses with wdata in order, each lasting 1 cycle; words_sent_o = 4; done_o pulses in the cycle after the 4th rvalid; error_flag = 0.
- cmd_len = 0:
  - Required: exactly BULK_NUMBER = 10 writes; words_sent_o = 10.
- Backpressure:
  - Stimulus: gnt held low for 50 cycles on word 2.
  - Required: req and wdata stable for all 50 cycles; transfer completes; error_flag = 0.
- Timeout:
  - Stimulus: TIMEOUT_LIMIT = 100; gnt never arrives on word 3.
  - Required: req drops after 100 cycles; ERR → done_o pulse; error_flag = 1; words_sent_o = 2; error_flag clears on the next command accept.
- Abort:
  - Stimulus: abort in RESP of word 1.
  - Required: waits for rvalid, words_sent_o = 1, done_o pulse.
  - Stimulus: abort in FETCH.
  - Required: immediate DONE with no req.
- Reset mid-REQ:
  - Stimulus: w_rst_n low for 1 cycle while in REQ.
  - Required: all outputs 0 on the next edge, cmd_ready_o = 1, no done_o pulse.

Source files
------------

// File: rtl/ipr_pkg.sv
// Shared types and constants for the IPR write/read initiators.
package ipr_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StReq,
    StResp,
    StDone,
    StErr
  } ipr_init_state_e;

  // IPR controller register offsets
  localparam logic [7:0] IprRegData  = 8'h00;
  localparam logic [7:0] IprRegFull  = 8'h04;
  localparam logic [7:0] IprRegEmpty = 8'h08;

endpackage

// File: rtl/ipr_write_if.sv
// Request/grant/response bus between a write initiator and the IPR controller write port.
interface ipr_write_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DSIZE  = 32
);

  logic              req;
  logic              we;
  logic [AWIDTH-1:0] addr;
  logic [DSIZE-1:0]  wdata;
  logic              gnt;
  logic              rvalid;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  gnt,
    input  rvalid
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output gnt,
    output rvalid
  );

endinterface

// File: rtl/ipr_watchdog.sv
// Saturating stall counter; expire flags the cycle in which the limit-th enabled cycle occurs.
module ipr_watchdog #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [Width-1:0] limit,
  output logic             expire
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero limit disables the watchdog entirely.
  assign expire = en && (limit != '0) && (cnt_q >= (limit - 1'b1));

endmodule

// File: rtl/ipr_write_initiator.sv
// Bulk write engine: pulls words from a valid/ready source and writes each to the IPR data register.
module ipr_write_initiator
  import ipr_pkg::*;
#(
  parameter int unsigned DSIZE         = 32,
  parameter int unsigned AWIDTH        = 32,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned TIMEOUT_LIMIT = 100,
  parameter int unsigned BULK_NUMBER   = 10
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [CNT_W-1:0]  cmd_len_i,
  input  logic [AWIDTH-1:0] cmd_addr_i,
  input  logic              abort_i,
  input  logic              src_valid_i,
  output logic              src_ready_o,
  input  logic [DSIZE-1:0]  src_data_i,
  ipr_write_if.master       ipr,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_flag,
  output logic [CNT_W-1:0]  words_sent_o
);

  localparam int unsigned WdW = (TIMEOUT_LIMIT > 1) ? $clog2(TIMEOUT_LIMIT + 1) : 1;

  ipr_init_state_e   state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic [CNT_W-1:0]  words_inc;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DSIZE-1:0]  wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              abort_pend_q, abort_pend_d;
  logic              wd_en, wd_expire;
  logic              req;

  assign wd_en     = (state_q == StReq) && !ipr.gnt;
  assign words_inc = words_q + 1'b1;

  ipr_watchdog #(
    .Width (WdW)
  ) u_watchdog (
    .clk    (w_clk),
    .rst_n  (w_rst_n),
    .clr    (!wd_en),
    .en     (wd_en),
    .limit  (WdW'(TIMEOUT_LIMIT)),
    .expire (wd_expire)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    words_d      = words_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    abort_pend_d = abort_pend_q;
    cmd_ready_o  = 1'b0;
    src_ready_o  = 1'b0;
    req          = 1'b0;
    done_o       = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          len_d        = (cmd_len_i == '0) ? CNT_W'(BULK_NUMBER) : cmd_len_i;
          addr_d       = cmd_addr_i;
          words_d      = '0;
          err_d        = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = StFetch;
        end
      end
      StFetch: begin
        src_ready_o = 1'b1;
        if (abort_i) begin
          state_d = StDone;
        end else if (src_valid_i) begin
          wdata_d = src_data_i;
          state_d = StReq;
        end
      end
      StReq: begin
        req = 1'b1;
        // A grant in the same cycle beats both abort and watchdog expiry.
        if (ipr.gnt) begin
          state_d = StResp;
          if (abort_i) begin
            abort_pend_d = 1'b1;
          end
        end else if (abort_i) begin
          state_d = StDone;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = StErr;
        end
      end
      StResp: begin
        if (abort_i) begin
          abort_pend_d = 1'b1;
        end
        if (ipr.rvalid) begin
          words_d = words_inc;
          if ((words_inc == len_q) || abort_pend_q || abort_i) begin
            state_d = StDone;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        done_o       = 1'b1;
        abort_pend_d = 1'b0;
        state_d      = StIdle;
      end
      StErr: begin
        done_o       = 1'b1;
        abort_pend_d = 1'b0;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state_q      <= StIdle;
      len_q        <= '0;
      words_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      words_q      <= words_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Address and data come straight from registers, so they stay put until the grant.
  assign ipr.req      = req;
  assign ipr.we       = req;
  assign ipr.addr     = addr_q;
  assign ipr.wdata    = wdata_q;
  assign busy_o       = (state_q != StIdle);
  assign error_flag   = err_q;
  assign words_sent_o = words_q;

endmodule
